// File: rtl/pim_input_buffer_write_mode.sv
// pim_input_buffer_write_mode
//   Input-side code buffer and pulse-width decoder for the PIM macro.
//   The CPU writes 4-bit row codes, eight per 32-bit word, into a row-indexed
//   buffer. On start the sequencer replays the buffer as a registered pulse
//   train: row i is driven high for exactly code_i cycles of a
//   (2^VAL_W-1)-cycle drive window.
// Ports
//   clk_i, rst_ni              clock, synchronous active-low reset
//   wdata_i                    write word, row 8w+k code in [4k+3:4k]
//   write_mode_buf_w_en_i      write strobe for word word_addr_i (IDLE only)
//   write_mode_buf_r_en_i      readback enable
//   word_addr_i                buffer word index
//   start_i, abort_i           start / abort drive sequence
//   rdata_o                    combinational readback word (0 when disabled)
//   busy_o, done_o             sequence busy, one-cycle end pulse
//   pim_input_o                registered row drive pattern
//   pim_input_valid_o          high while pim_input_o carries a pattern
module pim_input_buffer_write_mode #(
  parameter int unsigned NUM_ROWS = 128,
  parameter int unsigned VAL_W    = 4,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [31:0]         wdata_i,
  input  logic                write_mode_buf_w_en_i,
  input  logic                write_mode_buf_r_en_i,
  input  logic [ADDR_W-1:0]   word_addr_i,
  input  logic                start_i,
  input  logic                abort_i,
  output logic [31:0]         rdata_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [NUM_ROWS-1:0] pim_input_o,
  output logic                pim_input_valid_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Last counter value of the drive window: 2^VAL_W-2.
  localparam logic [VAL_W-1:0] CNT_LAST = {{(VAL_W-1){1'b1}}, 1'b0};

  state_e             state;
  logic [VAL_W-1:0]   cnt;
  logic [VAL_W-1:0]   codes [NUM_ROWS];
  logic [VAL_W-1:0]   thr;
  logic [NUM_ROWS-1:0] drive_pat;

  // Threshold for the pattern registered at the next edge: 0 when leaving
  // IDLE, otherwise the incremented counter.
  always_comb begin
    thr = '0;
    if (state == DRIVE) begin
      thr = cnt + VAL_W'(1);
    end
  end

  always_comb begin
    drive_pat = '0;
    for (int unsigned i = 0; i < NUM_ROWS; i++) begin
      drive_pat[i] = (codes[i] > thr);
    end
  end

  always_comb begin
    rdata_o = '0;
    if (write_mode_buf_r_en_i) begin
      for (int unsigned k = 0; k < 8; k++) begin
        rdata_o[VAL_W*k +: VAL_W] = codes[{word_addr_i, 3'(k)}];
      end
    end
  end

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state             <= IDLE;
      cnt               <= '0;
      pim_input_o       <= '0;
      pim_input_valid_o <= 1'b0;
      done_o            <= 1'b0;
      for (int unsigned i = 0; i < NUM_ROWS; i++) begin
        codes[i] <= '0;
      end
    end else if (abort_i) begin
      state             <= IDLE;
      cnt               <= '0;
      pim_input_o       <= '0;
      pim_input_valid_o <= 1'b0;
      done_o            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          // A write in the same cycle as start wins; start is dropped.
          if (write_mode_buf_w_en_i) begin
            for (int unsigned k = 0; k < 8; k++) begin
              codes[{word_addr_i, 3'(k)}] <= wdata_i[VAL_W*k +: VAL_W];
            end
          end else if (start_i) begin
            state             <= DRIVE;
            cnt               <= '0;
            pim_input_o       <= drive_pat;
            pim_input_valid_o <= 1'b1;
          end
        end
        DRIVE: begin
          if (cnt == CNT_LAST) begin
            state             <= DONE;
            cnt               <= '0;
            pim_input_o       <= '0;
            pim_input_valid_o <= 1'b0;
            done_o            <= 1'b1;
          end else begin
            cnt         <= cnt + VAL_W'(1);
            pim_input_o <= drive_pat;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
        end
        default: begin
          state             <= IDLE;
          cnt               <= '0;
          pim_input_o       <= '0;
          pim_input_valid_o <= 1'b0;
          done_o            <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pim_input_buffer_write_mode.sv
// Directed testbench for pim_input_buffer_write_mode.
module tb_pim_input_buffer_write_mode;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic [31:0]  wdata;
  logic         w_en;
  logic         r_en;
  logic [3:0]   addr;
  logic         start;
  logic         abort;
  logic [31:0]  rdata;
  logic         busy;
  logic         done;
  logic [127:0] pim;
  logic         valid;

  always #5 clk = ~clk;

  pim_input_buffer_write_mode #(
    .NUM_ROWS(128),
    .VAL_W   (4),
    .ADDR_W  (4)
  ) dut (
    .clk_i                (clk),
    .rst_ni               (rst_ni),
    .wdata_i              (wdata),
    .write_mode_buf_w_en_i(w_en),
    .write_mode_buf_r_en_i(r_en),
    .word_addr_i          (addr),
    .start_i              (start),
    .abort_i              (abort),
    .rdata_o              (rdata),
    .busy_o               (busy),
    .done_o               (done),
    .pim_input_o          (pim),
    .pim_input_valid_o    (valid)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] m_codes [128];
  int hi [8];
  int valid_n;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] exp_pat(input int k);
    logic [127:0] p;
    p = '0;
    for (int i = 0; i < 128; i++) p[i] = (int'(m_codes[i]) > k);
    return p;
  endfunction

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    w_en  = 1'b1;
    tick();
    w_en  = 1'b0;
    for (int k = 0; k < 8; k++) m_codes[{a, 3'(k)}] = d[4*k +: 4];
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    addr = a;
    r_en = 1'b1;
    #1;
    check(tag, rdata, exp);
    r_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Checks a sequence whose start edge has just passed. stop_k >= 0 ends it
  // with abort (or reset when by_rst) raised after observing cycle stop_k.
  // inject drives a write and a start during DRIVE, both of which must be ignored.
  task automatic run_seq(input int stop_k, input bit by_rst, input bit inject);
    valid_n = 0;
    for (int r = 0; r < 8; r++) hi[r] = 0;
    for (int k = 0; k < 15; k++) begin
      check($sformatf("pat_k%0d", k), pim, exp_pat(k));
      check($sformatf("valid_k%0d", k), valid, 1'b1);
      check($sformatf("busy_k%0d", k), busy, 1'b1);
      check($sformatf("done_k%0d", k), done, 1'b0);
      valid_n += int'(valid);
      for (int r = 0; r < 8; r++) hi[r] += int'(pim[r]);
      if (inject && k == 2) begin
        addr = 4'd1; wdata = 32'hFFFF_FFFF; w_en = 1'b1; start = 1'b1;
      end
      if (inject && k == 4) begin
        w_en = 1'b0; start = 1'b0;
      end
      if (k == stop_k) begin
        if (by_rst) rst_ni = 1'b0;
        else        abort  = 1'b1;
        tick();
        rst_ni = 1'b1;
        abort  = 1'b0;
        check("stop_pim", pim, '0);
        check("stop_valid", valid, 1'b0);
        check("stop_busy", busy, 1'b0);
        check("stop_done", done, 1'b0);
        if (by_rst) for (int i = 0; i < 128; i++) m_codes[i] = '0;
        tick();
        check("stop_done_next", done, 1'b0);
        check("stop_busy_next", busy, 1'b0);
        return;
      end
      tick();
    end
    check("end_done", done, 1'b1);
    check("end_valid", valid, 1'b0);
    check("end_pim", pim, '0);
    check("end_busy", busy, 1'b1);
    tick();
    check("idle_done", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("valid_cycles", 128'(valid_n), 128'(15));
  endtask

  initial begin
    rst_ni = 1'b0; wdata = '0; w_en = 1'b0; r_en = 1'b0;
    addr = '0; start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 128; i++) m_codes[i] = '0;

    // Reset state
    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_pim", pim, '0);
    rd_check("rst_rdata", 4'd0, 32'h0);
    rst_ni = 1'b1;
    tick();

    // Write / readback
    bus_wr(4'd0, 32'h7654_3210);
    rd_check("rd_w0", 4'd0, 32'h7654_3210);
    rd_check("rd_w1", 4'd1, 32'h0);
    rd_check("rd_w15", 4'd15, 32'h0);
    addr = 4'd0;
    #1;
    check("rd_disabled", rdata, 32'h0);

    // Full sequence with boundary codes, plus ignored write/start during DRIVE
    bus_wr(4'd0, 32'h3FE8_7210);
    bus_wr(4'd1, 32'h1234_5678);
    do_start();
    run_seq(-1, 1'b0, 1'b1);
    check("hi_row0", 128'(hi[0]), 128'(0));
    check("hi_row1", 128'(hi[1]), 128'(1));
    check("hi_row3", 128'(hi[3]), 128'(7));
    check("hi_row4", 128'(hi[4]), 128'(8));
    check("hi_row5", 128'(hi[5]), 128'(14));
    check("hi_row6", 128'(hi[6]), 128'(15));
    check("hi_row7", 128'(hi[7]), 128'(3));
    rd_check("rd_w1_kept", 4'd1, 32'h1234_5678);
    tick();

    // Write and start in the same IDLE cycle: write lands, start dropped
    addr = 4'd0; wdata = 32'h0000_00F5; w_en = 1'b1; start = 1'b1;
    tick();
    w_en = 1'b0; start = 1'b0;
    for (int k = 0; k < 8; k++) m_codes[k] = wdata[4*k +: 4];
    check("ws_busy", busy, 1'b0);
    check("ws_valid", valid, 1'b0);
    rd_check("ws_rdata", 4'd0, 32'h0000_00F5);
    tick();
    check("ws_busy_later", busy, 1'b0);

    // Abort at cycle 5, then a full replay of the retained buffer
    do_start();
    run_seq(5, 1'b0, 1'b0);
    do_start();
    run_seq(-1, 1'b0, 1'b0);
    check("hi_row0_f5", 128'(hi[0]), 128'(5));
    check("hi_row1_f5", 128'(hi[1]), 128'(15));
    tick();

    // Reset at cycle 7 of DRIVE zeroes the buffer
    do_start();
    run_seq(7, 1'b1, 1'b0);
    rd_check("rst_w0", 4'd0, 32'h0);
    rd_check("rst_w1", 4'd1, 32'h0);
    do_start();
    run_seq(-1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
